regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between several writeback requesters, such as the ALU result and the load unit. It does this with a valid/ready handshake and round-robin arbitration. It registers the winning write into a one-stage output that drives the regfile `we`/`rd`/`wd` pins. It also keeps a 32-entry busy scoreboard: issue logic reserves destination registers, and committed writes release them, so the decode stage can stall on RAW hazards.

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_if.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 65 ++++++
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions used by the writeback arbiter slice.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  function automatic logic is_zero_reg(input reg_addr_t rd);
    return rd == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: per-requester valid/ready handshake with packed rd/wd.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_wd;

  modport master (output req_valid, output req_rd, output req_wd, input req_ready);
  modport slave  (input req_valid, input req_rd, input req_wd, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// RF_WB_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      req,
  output logic [N-1:0]                      gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (!rst) begin
      for (int unsigned i = N; i > 0; i--) begin
        if (req[i-1]) begin
          gnt     = '0;
          gnt[i-1] = 1'b1;
          gnt_idx = IW'(i-1);
        end
      end
    end
  end
`else
  logic [IW-1:0] last;
  logic [IW-1:0] cand;
  logic          found;

  // Walk offsets last+1 .. last+N; the inner loop keeps every index a constant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (!rst) begin
      for (int unsigned off = 1; off <= N; off++) begin
        cand = IW'((32'(last) + off) % N);
        for (int unsigned i = 0; i < N; i++) begin
          if (!found && IW'(i) == cand && req[i]) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= IW'(N-1);
    end else if (|gnt) begin
      last <= gnt_idx;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter: grants one requester per cycle, registers the write
// onto the regfile pins and tracks outstanding writes in a busy scoreboard.
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [2**AW-1:0]     busy
);
  import regfile_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_wd;
  logic [2**AW-1:0] busy_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wb.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign wb.req_ready = gnt;

  always_comb begin
    win_rd = '0;
    win_wd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        win_rd = wb.req_rd[i*AW +: AW];
        win_wd = wb.req_wd[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are accepted but never reach the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (|gnt) begin
      rf_we <= (win_rd != AW'(ZERO_REG));
      rf_rd <= win_rd;
      rf_wd <= win_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Set is applied after clear so a new reservation survives a same-cycle commit.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) begin
      busy_nxt[rf_rd] = 1'b0;
    end
    if (iss_valid && iss_rd != AW'(ZERO_REG)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=2) with a regfile model.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [31:0]     busy;
  logic [31:0]     rfm [32];
  logic [1:0]      exp_gnt;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) wb ();

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rfm[rf_rd] <= rf_wd;
  end

  function automatic logic [31:0] rf_read(input int unsigned r);
    return (r == 0) ? 32'd0 : rfm[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] rd, input logic [XLEN-1:0] wd);
    wb.req_rd[i*AW +: AW]     = rd;
    wb.req_wd[i*XLEN +: XLEN] = wd;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rfm[i] = '0;
    rst = 1'b1;
    iss_valid = 1'b0;
    iss_rd = '0;
    wb.req_valid = '0;
    wb.req_rd = '0;
    wb.req_wd = '0;

    // Reset: ready forced low even with valid requests
    #1;
    wb.req_valid = 2'b11;
    #1;
    chk("ready_in_rst", 32'(wb.req_ready), 32'h0);
    wb.req_valid = 2'b00;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_rd", 32'(rf_rd), 32'h0);
    chk("rst_wd", rf_wd, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_ready", 32'(wb.req_ready), 32'h0);

    // Single writer x1=10, then x2=20 back-to-back
    set_req(0, 5'd1, 32'd10);
    wb.req_valid = 2'b01;
    #1;
    chk("w1_ready", 32'(wb.req_ready), 32'h1);
    step();
    chk("w1_we", 32'(rf_we), 32'h1);
    chk("w1_rd", 32'(rf_rd), 32'd1);
    chk("w1_wd", rf_wd, 32'd10);
    set_req(0, 5'd2, 32'd20);
    step();
    chk("w2_we", 32'(rf_we), 32'h1);
    chk("w2_rd", 32'(rf_rd), 32'd2);
    wb.req_valid = 2'b00;
    step();
    chk("idle_we", 32'(rf_we), 32'h0);
    chk("idle_rd_hold", 32'(rf_rd), 32'd2);
    chk("idle_wd_hold", rf_wd, 32'd20);
    chk("read_x1", rf_read(1), 32'd10);
    chk("read_x2", rf_read(2), 32'd20);

    // x0 write from requester 1: accepted, discarded
    set_req(1, 5'd0, 32'd99);
    wb.req_valid = 2'b10;
    #1;
    chk("x0_ready", 32'(wb.req_ready), 32'h2);
    step();
    wb.req_valid = 2'b00;
    chk("x0_we", 32'(rf_we), 32'h0);
    chk("x0_rd", 32'(rf_rd), 32'd0);
    chk("x0_wd", rf_wd, 32'd99);
    step();
    chk("read_x0", rf_read(0), 32'd0);

    // Contention: last grant was requester 1
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd4, 32'h44);
    wb.req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      exp_gnt = 2'b01;
`else
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #1;
      chk("cont_ready", 32'(wb.req_ready), 32'(exp_gnt));
      step();
      chk("cont_we", 32'(rf_we), 32'h1);
      chk("cont_rd", 32'(rf_rd), (exp_gnt == 2'b01) ? 32'd3 : 32'd4);
    end
    wb.req_valid = 2'b00;
    step();
    chk("read_x3", rf_read(3), 32'h33);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
    chk("read_x4", rf_read(4), 32'h0);
`else
    chk("read_x4", rf_read(4), 32'h44);
`endif

    // Scoreboard: reserve x5, commit clears at N+2
    iss_valid = 1'b1;
    iss_rd = 5'd5;
    step();
    iss_valid = 1'b0;
    chk("sb_set", busy, 32'h20);
    set_req(0, 5'd5, 32'h55);
    wb.req_valid = 2'b01;
    step();
    wb.req_valid = 2'b00;
    chk("sb_n1_busy", busy, 32'h20);
    chk("sb_n1_we", 32'(rf_we), 32'h1);
    step();
    chk("sb_n2_clear", busy, 32'h0);
    chk("read_x5", rf_read(5), 32'h55);

    // Set and clear of x5 on the same edge: set wins
    iss_valid = 1'b1;
    step();
    iss_valid = 1'b0;
    set_req(0, 5'd5, 32'h56);
    wb.req_valid = 2'b01;
    step();
    wb.req_valid = 2'b00;
    iss_valid = 1'b1;
    chk("sb_same_we", 32'(rf_we), 32'h1);
    step();
    iss_valid = 1'b0;
    chk("sb_set_wins", busy, 32'h20);

    // Reserving x0 never marks it busy
    iss_valid = 1'b1;
    iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("sb_x0", busy, 32'h20);

    // Reset mid-write of x6
    set_req(0, 5'd6, 32'h60);
    wb.req_valid = 2'b01;
    step();
    wb.req_valid = 2'b00;
    step();
    chk("read_x6_old", rf_read(6), 32'h60);
    set_req(0, 5'd6, 32'h66);
    wb.req_valid = 2'b01;
    step();
    chk("mid_we_before", 32'(rf_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_we_drop", 32'(rf_we), 32'h0);
    chk("mid_busy", busy, 32'h0);
    chk("mid_ready", 32'(wb.req_ready), 32'h0);
    step();
    rst = 1'b0;
    wb.req_valid = 2'b00;
    step();
    chk("read_x6_kept", rf_read(6), 32'h60);
    chk("post_rst_rd", 32'(rf_rd), 32'h0);

    // Pointer restored to NREQ-1: requester 0 wins first
    wb.req_valid = 2'b11;
    #1;
    chk("post_rst_gnt", 32'(wb.req_ready), 32'h1);
    wb.req_valid = 2'b00;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
